// File: rtl/spy_read_sched_if.sv
// Requester-side bus and FIFO read-port bundles for the spy-buffer read scheduler.
// spy_req_if: requesters are master and the scheduler is slave. spy_fifo_rd_if: the scheduler is master.
interface spy_req_if #(
  parameter int NREQ  = 2,
  parameter int DATAW = 32,
  parameter int LENW  = 8
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][LENW-1:0] req_len;
  logic [NREQ-1:0]           out_ready;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           done;
  logic                      aborted;
  logic [DATAW-1:0]          out_data;
  logic [NREQ-1:0]           out_valid;

  modport master (output req, req_len, out_ready,
                  input  gnt, done, aborted, out_data, out_valid);
  modport slave  (input  req, req_len, out_ready,
                  output gnt, done, aborted, out_data, out_valid);
endinterface

interface spy_fifo_rd_if #(
  parameter int DATAW = 32
);
  logic             fifo_rempty;
  logic [DATAW-1:0] fifo_rdata;
  logic             fifo_rinc;

  modport master (input  fifo_rempty, fifo_rdata, output fifo_rinc);
  modport slave  (output fifo_rempty, fifo_rdata, input  fifo_rinc);
endinterface

// File: rtl/spy_read_sched.sv
// Round-robin burst scheduler sharing one spy-FIFO read port among NREQ requesters.
// Optional stall timeout: define SPY_SCHED_TIMEOUT_EN.

// Per-requester output decode from the shared grant state.
module spy_sched_lane (
  input  logic sel,
  input  logic in_burst,
  input  logic in_fin,
  input  logic rinc,
  output logic gnt,
  output logic done,
  output logic out_valid
);
  assign gnt       = sel & (in_burst | in_fin);
  assign done      = sel & in_fin;
  assign out_valid = sel & in_burst & rinc;
endmodule

module spy_read_sched #(
  parameter int NREQ  = 2,
  parameter int DATAW = 32,
  parameter int LENW  = 8,
  parameter int TOW   = 10
) (
  input  logic          rclk,
  input  logic          rrst,
  spy_req_if.slave      rq,
  spy_fifo_rd_if.master fifo,
  output logic [15:0]   words_total
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BURST, FIN} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   g, g_nxt;
  logic [GW-1:0]   last, last_nxt;
  logic [LENW-1:0] cnt, cnt_nxt;
  logic            ab, ab_nxt;
  logic            rinc;
  logic            any_req;
  logic [GW-1:0]   pick;

`ifdef SPY_SCHED_TIMEOUT_EN
  logic [TOW-1:0]  stall, stall_nxt;
`else
  logic            tow_unused;
  assign tow_unused = (TOW > 0);
`endif

  // Read only when the FIFO has data, the owner accepts, and the owner still wants the burst.
  assign rinc           = (state == BURST) & ~fifo.fifo_rempty & rq.out_ready[g] & rq.req[g];
  assign fifo.fifo_rinc = rinc;
  assign rq.out_data    = fifo.fifo_rdata;
  assign rq.aborted     = (state == FIN) & ab;

  // Scan last+NREQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    logic [GW:0] sum;
    any_req = 1'b0;
    pick    = '0;
    sum     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, last} + (GW+1)'(k);
      if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
      if (rq.req[sum[GW-1:0]]) begin
        any_req = 1'b1;
        pick    = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    cnt_nxt   = cnt;
    last_nxt  = last;
    ab_nxt    = ab;
`ifdef SPY_SCHED_TIMEOUT_EN
    stall_nxt = stall;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          g_nxt     = pick;
          cnt_nxt   = rq.req_len[pick];
          ab_nxt    = 1'b0;
          state_nxt = (rq.req_len[pick] == '0) ? FIN : BURST;
`ifdef SPY_SCHED_TIMEOUT_EN
          stall_nxt = '0;
`endif
        end
      end
      BURST: begin
        if (!rq.req[g]) begin
          state_nxt = FIN;
          ab_nxt    = 1'b1;
        end else if (rinc) begin
          cnt_nxt = cnt - LENW'(1);
          if (cnt == LENW'(1)) begin
            state_nxt = FIN;
            ab_nxt    = 1'b0;
          end
`ifdef SPY_SCHED_TIMEOUT_EN
          stall_nxt = '0;
        end else begin
          // A stalled owner or dry FIFO gives up the port once the counter saturates.
          stall_nxt = stall + TOW'(1);
          if (&stall_nxt) begin
            state_nxt = FIN;
            ab_nxt    = 1'b1;
          end
`endif
        end
      end
      FIN: begin
        last_nxt  = g;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state       <= IDLE;
      g           <= '0;
      cnt         <= '0;
      last        <= GW'(NREQ-1);
      ab          <= 1'b0;
      words_total <= '0;
`ifdef SPY_SCHED_TIMEOUT_EN
      stall       <= '0;
`endif
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      ab    <= ab_nxt;
`ifdef SPY_SCHED_TIMEOUT_EN
      stall <= stall_nxt;
`endif
      if (rinc && !(&words_total)) words_total <= words_total + 16'd1;
    end
  end

  logic [NREQ-1:0] gnt_v, done_v, vld_v;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    spy_sched_lane u_lane (
      .sel       (g == GW'(i)),
      .in_burst  (state == BURST),
      .in_fin    (state == FIN),
      .rinc      (rinc),
      .gnt       (gnt_v[i]),
      .done      (done_v[i]),
      .out_valid (vld_v[i])
    );
  end

  assign rq.gnt       = gnt_v;
  assign rq.done      = done_v;
  assign rq.out_valid = vld_v;
endmodule

// File: doc/spy_read_sched.md
Name: spy_read_sched

Overview:
- Read-side scheduler for one spy-buffer async FIFO, in the read clock domain.
- Shares the FIFO's single read port among NREQ requesters (e.g. playback and slow-control readout) using round-robin arbitration.
- Each grant is a bounded burst of req_len words; the block drives fifo_rinc and steers fifo_rdata to the granted requester.
- Enforces empty and backpressure rules at the FIFO port.

Parameters:
- NREQ, 2: number of requesters (2..8).
- DATAW, 32: FIFO data width.
- LENW, 8: burst-length field width; maximum burst is 2^LENW-1 words.
- TOW, 10: width of the stall-timeout counter (used only with the optional feature).

Ports:
- rclk  in  1  read-domain clock; all logic on rising edge.
- rrst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester burst request; level; held until done.
- req_len  in  NREQ*LENW  burst length, slice i for requester i; sampled at grant.
- out_ready  in  NREQ  per-requester accept.
- gnt  out  NREQ  one-hot grant; all zero when idle.
- done  out  NREQ  one-cycle pulse at end of burst for requester i.
- aborted  out  1  qualifies done; 1 means the burst ended early.
- out_data  out  DATAW  fifo_rdata passed through combinationally.
- out_valid  out  NREQ  word valid for the granted requester.
- fifo_rempty  in  1  FIFO empty flag (registered inside the FIFO).
- fifo_rdata  in  DATAW  word at the current FIFO read address.
- fifo_rinc  out  1  read increment to the FIFO.
- words_total  out  16  saturating count of words read since reset.

Behaviour:
- Reset (sync, rrst=1 at the clock edge):
  - state=IDLE, gnt=0, done=0, aborted=0, fifo_rinc=0, out_valid=0, words_total=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, BURST, FIN.
- IDLE:
  - If any req bit is set, select the first set bit scanning last+1, last+2, … modulo NREQ.
  - Register g (the selected index), cnt=req_len[g], gnt=onehot(g).
  - If cnt==0, go to FIN with aborted=0 and no reads. Otherwise go to BURST.
  - Grant latency is 1 cycle from req seen in IDLE.
- BURST:
  - fifo_rinc = ~fifo_rempty & out_ready[g] & req[g], combinational from registered state.
  - out_valid[g]=fifo_rinc; every other out_valid bit is 0. The word on out_data is consumed in the same cycle as fifo_rinc.
  - Each cycle with fifo_rinc: cnt decrements and words_total increments, saturating at 0xFFFF.
  - When fifo_rinc and cnt==1, go to FIN with aborted=0.
  - If req[g]=0 at any BURST cycle, go to FIN with aborted=1; no fifo_rinc that cycle.
  - Empty or out_ready=0 simply stalls: cnt holds and the state holds.
- FIN (1 cycle):
  - done[g]=1, aborted as registered, gnt still onehot(g).
  - last=g; next state IDLE, where gnt becomes 0.
  - Minimum spacing from done to the next grant is 2 cycles (FIN→IDLE→BURST).
- Simultaneous events:
  - In IDLE, requests that arrive together are resolved only by round robin.
  - A requester that just finished has lowest priority next time.
  - The winner is re-evaluated only in IDLE; in-progress bursts are never preempted.
- fifo_rinc is never asserted while fifo_rempty=1. The FIFO also gates rinc internally, but the scheduler must not rely on that.
- req_len changes after grant are ignored.
- Reset mid-burst: all state clears on the next edge, with no done pulse. Words already read are lost, which is acceptable.

Optional Feature:
- Macro: SPY_SCHED_TIMEOUT_EN.
- Defined:
  - A TOW-bit stall counter clears on grant and on each fifo_rinc.
  - It increments each BURST cycle without fifo_rinc.
  - At all-ones it forces FIN with aborted=1, releasing the read port from a stalled requester or a dry FIFO.
- Undefined: no counter is instantiated, and a burst waits indefinitely. Port list is identical in both builds.

Test Plan:
- Single burst: FIFO preloaded with 5 words (0xA0..0xA4), req[0]=1, req_len0=4, out_ready=1 → gnt=01 one cycle later; 4 consecutive fifo_rinc cycles carrying 0xA0..0xA3; done[0] pulses with aborted=0; words_total=4; FIFO not empty.
- Round robin: req=11 held, lengths 2 and 2, FIFO holds 8 words → grant order 0,1,0,1; exactly 2 words per burst; no gap beyond FIN+IDLE.
- Empty stall: FIFO empty, req[1]=1, len=3; write 3 words 20 cycles later → no fifo_rinc while empty; 3 reads after data arrives; done[1] then aborted=0.
- Backpressure and abort: len=6, out_ready[0] toggles 1010…, deassert req[0] after 2 words → reads only when ready; done[0] with aborted=1; cnt not reused; next grant goes to requester 1 if it is requesting.
- Zero length and reset: req_len=0 → done in FIN with no fifo_rinc. Assert rrst mid-burst → next cycle gnt=0, fifo_rinc=0, words_total=0, no done.
- With SPY_SCHED_TIMEOUT_EN, TOW=4: out_ready[0] held 0 in BURST → FIN after 15 stall cycles, done[0]=1, aborted=1. Without the macro → still in BURST after 100 cycles.
